score_digits: RTL and testbench
===============================

SCORE_DIGITS -- requirements
Module: score_digits

Interface
REQ-001 Parameter VAL_W, default 10: binary input width.
REQ-002 Parameter NDIG, default 3: decimal digits produced; hundreds, tens, units.
REQ-003 Parameter NUM_W, default 6: width of each digit output, matching the glyph renderer's num input.
REQ-004 clk  in  1: single system clock; all state changes on its rising edge.
REQ-005 reset  in  1: synchronous, active-high reset, sampled on the clk rising edge.
REQ-006 value  in  VAL_W: unsigned binary score to convert.
REQ-007 load  in  1: one-cycle request to convert value.
REQ-008 frame_start  in  1: one-cycle pulse at the start of vertical blanking.
REQ-009 ready  out  1: high when a load will be accepted, i.e. state IDLE.
REQ-010 busy  out  1: high while a conversion is in progress, i.e. state SHIFT.
REQ-011 pending  out  1: a converted result is waiting for the next frame_start.
REQ-012 num2, num1, num0  out  NUM_W each: displayed hundreds, tens and units digits, zero-extended 0..9.

Function
REQ-013 The state machine SHALL have two states. IDLE --(load && !reset)--> SHIFT. SHIFT --(iteration counter == VAL_W-1)--> IDLE.
REQ-014 On an accepted load at cycle N, the block SHALL capture min(value, 999) into the shift register, clear the BCD accumulator and counter, and enter SHIFT.
REQ-015 SHIFT SHALL perform one double-dabble iteration per cycle: add 3 to each BCD nibble >= 5, then shift the combined register left by one.
REQ-016 busy SHALL be high for exactly VAL_W cycles, N+1 through N+VAL_W.
REQ-017 On the final iteration edge, the block SHALL write the BCD result to shadow registers and set pending; pending is first visible at N+VAL_W+1.
REQ-018 A load while in SHIFT SHALL be ignored with no queuing; the in-flight conversion continues unchanged.
REQ-019 Inputs above 999 SHALL saturate to digits 9,9,9.
REQ-020 num2..num0 SHALL change only on a cycle where frame_start=1 and pending=1 at that edge: copy shadow to outputs and clear pending.
REQ-021 If pending is set on the same edge frame_start is sampled, the transfer SHALL wait for the next frame_start.
REQ-022 A frame_start with pending=0 SHALL leave the outputs unchanged.
REQ-023 A new conversion completing while pending=1 SHALL overwrite the shadow registers; the latest result wins and pending stays 1.
REQ-024 A load accepted in the same cycle as a frame_start transfer SHALL proceed normally; the two actions are independent.

Reset
REQ-025 With reset high, on the next edge: state IDLE, counter 0, shift register and shadow 0, pending 0, num2..num0 0, busy 0, ready 1.
REQ-026 Reset SHALL take priority over load and frame_start, and SHALL abort any conversion in progress with no partial result reaching shadow or outputs.

Structure
REQ-027 A shared package SHALL hold VAL_W, NDIG, NUM_W, the saturation limit 999, and the state encoding IDLE=0, SHIFT=1.
REQ-028 The per-nibble add-3 correction SHALL be a combinational sub-module, bcd_add3, instantiated NDIG times.
REQ-029 Outputs SHALL be registered, with no combinational path from value to num*.

Verification
REQ-030 Directed scenarios:
- Reset, then load value=255 -> busy high 10 cycles, pending=1 at N+11; after frame_start, num2/num1/num0 = 2/5/5.
- Load 0, then load 999 -> outputs 0/0/0, then 9/9/9; load 1023 -> 9/9/9 (saturation).
- Load 42, then load 7 at N+3 while busy -> second load ignored; outputs 0/4/2 after frame_start.
- Load 123 with no frame_start for 50 cycles -> outputs hold the old value and pending=1; a frame_start pulse -> 1/2/3 on the next cycle and pending=0.
- Load 500, then assert reset at N+5 -> busy=0, pending=0, outputs 0/0/0; a later frame_start leaves outputs at 0/0/0.
- Convert 321, then convert 654 before any frame_start -> a single frame_start shows 6/5/4 (latest wins).

Source files
------------

// File: rtl/score_digits_pkg.sv
// Shared constants and state encoding for the score-to-decimal converter.
package score_digits_pkg;
  localparam int VAL_W     = 10;
  localparam int NDIG      = 3;
  localparam int NUM_W     = 6;
  localparam int SAT_LIMIT = 999;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;
endpackage

// File: rtl/score_digits_bcd_add3.sv
// Double-dabble nibble correction: add 3 when the BCD digit is 5 or more.
module bcd_add3 (
  input  logic [3:0] din,
  output logic [3:0] dout
);
  always_comb begin
    dout = din;
    if (din >= 4'd5) dout = din + 4'd3;
  end
endmodule

// File: rtl/score_digits.sv
// Serial binary-to-BCD score converter; results are shadowed and shown on
// the display registers only at the next frame_start (vertical blanking).
module score_digits #(
  parameter int VAL_W = score_digits_pkg::VAL_W,
  parameter int NDIG  = score_digits_pkg::NDIG,
  parameter int NUM_W = score_digits_pkg::NUM_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [VAL_W-1:0] value,
  input  logic             load,
  input  logic             frame_start,
  output logic             ready,
  output logic             busy,
  output logic             pending,
  output logic [NUM_W-1:0] num2,
  output logic [NUM_W-1:0] num1,
  output logic [NUM_W-1:0] num0
);
  import score_digits_pkg::*;

  localparam int BCD_W = NDIG * 4;
  localparam int CNT_W = $clog2(VAL_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VAL_W - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VAL_W-1:0] bin_q, bin_d, bin_next, bin_sat;
  logic [BCD_W-1:0] bcd_q, bcd_d, bcd_fix, bcd_next;
  logic [BCD_W-1:0] shadow_q, shadow_d;
  logic [BCD_W-1:0] disp_q, disp_d;
  logic             pending_q, pending_d;

  for (genvar g = 0; g < NDIG; g++) begin : g_add3
    bcd_add3 u_add3 (
      .din  (bcd_q[g*4 +: 4]),
      .dout (bcd_fix[g*4 +: 4])
    );
  end

  always_comb begin
    {bcd_next, bin_next} = {bcd_fix, bin_q} << 1;
    bin_sat = value;
    if (int'(value) > SAT_LIMIT) bin_sat = VAL_W'(SAT_LIMIT);
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    disp_d    = disp_q;

    if (frame_start && pending_q) begin
      disp_d    = shadow_q;
      pending_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = SHIFT;
          bin_d   = bin_sat;
          bcd_d   = '0;
          cnt_d   = '0;
        end
      end
      SHIFT: begin
        bin_d = bin_next;
        bcd_d = bcd_next;
        cnt_d = cnt_q + CNT_W'(1);
        // A completing conversion re-arms pending even if a transfer fires now.
        if (cnt_q == LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          shadow_d  = bcd_next;
          pending_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bin_q     <= '0;
      bcd_q     <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      disp_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      disp_q    <= disp_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign busy    = (state_q == SHIFT);
  assign pending = pending_q;
  assign num2    = {{(NUM_W-4){1'b0}}, disp_q[11:8]};
  assign num1    = {{(NUM_W-4){1'b0}}, disp_q[7:4]};
  assign num0    = {{(NUM_W-4){1'b0}}, disp_q[3:0]};
endmodule

// File: tb/tb_score_digits.sv
// Directed bench for score_digits: expected display contents are queued at
// each frame_start and checked by a monitor just after the sampling edge.
module tb_score_digits;
  localparam int W = 19;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [9:0] value = '0;
  logic       load = 1'b0;
  logic       frame_start = 1'b0;
  logic       ready, busy, pending;
  logic [5:0] num2, num1, num0;

  logic [W-1:0] exp_q[$];
  int n_checks = 0;
  int n_pass = 0;

  score_digits dut (
    .clk(clk), .reset(reset), .value(value), .load(load),
    .frame_start(frame_start), .ready(ready), .busy(busy),
    .pending(pending), .num2(num2), .num1(num1), .num0(num0)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W-1:0] pack(input logic p, input int d2, input int d1, input int d0);
    return {p, 6'(d2), 6'(d1), 6'(d0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Monitor: each frame_start edge pops one expected {pending, num2, num1, num0}.
  always @(posedge clk) begin
    if (frame_start && !reset) begin
      #1;
      if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
      else check("frame_display", 32'({pending, num2, num1, num0}), 32'(exp_q.pop_front()));
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [9:0] v);
    value = v;
    load  = 1'b1;
    @(negedge clk);
    load  = 1'b0;
  endtask

  task automatic frame(input logic [W-1:0] exp);
    exp_q.push_back(exp);
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
  endtask

  task automatic wait_done();
    int k = 0;
    while (!ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    check("done_timeout", 32'(ready), 1);
  endtask

  initial begin
    tick(3);
    reset = 1'b0;
    check("rst_ready", 32'(ready), 1);
    check("rst_busy", 32'(busy), 0);
    check("rst_pending", 32'(pending), 0);
    check("rst_nums", 32'({num2, num1, num0}), 0);

    // 255: busy exactly 10 cycles, pending at N+11
    do_load(10'd255);
    check("s1_busy_n1", 32'(busy), 1);
    tick(9);
    check("s1_busy_n10", 32'(busy), 1);
    check("s1_pend_n10", 32'(pending), 0);
    tick(1);
    check("s1_busy_n11", 32'(busy), 0);
    check("s1_pend_n11", 32'(pending), 1);
    frame(pack(0, 2, 5, 5));

    // 0, 999, and saturation of 1023
    do_load(10'd0);    wait_done(); frame(pack(0, 0, 0, 0));
    do_load(10'd999);  wait_done(); frame(pack(0, 9, 9, 9));
    do_load(10'd1023); wait_done(); frame(pack(0, 9, 9, 9));

    // second load while busy is ignored
    do_load(10'd42);
    tick(2);
    do_load(10'd7);
    check("s3_busy_n4", 32'(busy), 1);
    tick(7);
    check("s3_ready_n11", 32'(ready), 1);
    check("s3_pend_n11", 32'(pending), 1);
    frame(pack(0, 0, 4, 2));

    // outputs hold across a long wait without frame_start
    do_load(10'd123);
    wait_done();
    tick(50);
    check("s4_hold_nums", 32'({num2, num1, num0}), 32'(pack(0, 0, 4, 2)));
    check("s4_hold_pend", 32'(pending), 1);
    frame(pack(0, 1, 2, 3));

    // reset aborts an in-flight conversion
    do_load(10'd500);
    tick(4);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("s5_busy", 32'(busy), 0);
    check("s5_ready", 32'(ready), 1);
    check("s5_pend", 32'(pending), 0);
    check("s5_nums", 32'({num2, num1, num0}), 0);
    tick(12);
    frame(pack(0, 0, 0, 0));

    // latest result wins, then an idle frame_start changes nothing
    do_load(10'd321); wait_done();
    do_load(10'd654); wait_done();
    check("s6_pend", 32'(pending), 1);
    frame(pack(0, 6, 5, 4));
    frame(pack(0, 6, 5, 4));

    // frame_start on the completion edge waits for the next one
    do_load(10'd88);
    tick(9);
    frame(pack(1, 6, 5, 4));
    // transfer and a new load on the same edge are independent
    value = 10'd77;
    load  = 1'b1;
    frame(pack(0, 0, 8, 8));
    load  = 1'b0;
    check("s8_busy", 32'(busy), 1);
    wait_done();
    frame(pack(0, 0, 7, 7));

    tick(3);
    check("queue_drained", 32'(exp_q.size()), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
